// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory responder: FSM states, counter width
// and the address-error decode used at the access edge.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam int CNT_W = 4;

   // A request faults when it is not word aligned or lies above the array.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned addr_width);
      logic [31:0] hi;
      hi = addr >> (addr_width + 2);
      return (addr[1:0] != 2'b00) || (hi != 32'd0);
   endfunction

endpackage

// File: rtl/datamem_array.sv
// Single-port word array: synchronous write, combinational read on the same
// address. Contents survive reset.
module datamem_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   // NOTE: storage arrays carry no reset branch; clearing them would turn the
   // RAM into a huge bank of flops, and software never relies on initial data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's data-memory port: accepts one load/store, waits a
// fixed latency, then presents read data or a write acknowledgement.
module data_mem_responder
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic                    err_q, err_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [31:0]             resp_rdata_q, resp_rdata_d;
   logic                    resp_err_q, resp_err_d;

   logic                    access;
   logic                    acc_we;
   logic                    acc_err;
   logic [ADDR_WIDTH-1:0]   acc_idx;
   logic [31:0]             acc_wdata;
   logic                    mem_we;
   logic [31:0]             mem_rdata;

   // NOTE: every signal assigned here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      err_d        = err_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      access       = 1'b0;
      acc_we       = we_q;
      acc_err      = err_q;
      acc_idx      = idx_q;
      acc_wdata    = wdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               err_d   = addr_err(req_addr, ADDR_WIDTH);
               idx_d   = req_addr[ADDR_WIDTH+1:2];
               wdata_d = req_wdata;
               if (LATENCY == 1) begin
                  // Single-cycle latency performs the access straight off the request bus.
                  access    = 1'b1;
                  acc_we    = req_we;
                  acc_err   = addr_err(req_addr, ADDR_WIDTH);
                  acc_idx   = req_addr[ADDR_WIDTH+1:2];
                  acc_wdata = req_wdata;
                  state_d   = RESP;
               end else begin
                  cnt_d   = LOAD_CNT;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q <= 4'd1) begin
               access  = 1'b1;
               cnt_d   = '0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (access) begin
         resp_rdata_d = (acc_we || acc_err) ? 32'd0 : mem_rdata;
         resp_err_d   = acc_err;
      end
   end

   // Reset on the access edge must suppress the store, so it gates the write.
   assign mem_we = access && acc_we && !acc_err && !reset;

   datamem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (mem_rdata)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         err_q        <= err_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule
